// File: rtl/image_streamer.sv
// -----------------------------------------------------------------------------
// image_streamer
//   Snapshots a 32x32 one-bit bitmap on a start request and streams it out as
//   1024 pixel words over a valid/ready handshake, counting set pixels on the way.
//
// Configuration macro:
//   IMG_STREAM_ROW_MAJOR_EN  defined   -> row-major order (y outer, x inner):
//                                         position p reads bit {p[4:0], p[9:5]}
//                            undefined -> column-major order: position p reads bit p
//
// Ports:
//   iBusClk    in   1      clock, all logic on rising edge
//   iRst       in   1      synchronous active-high reset
//   iImage     in   1024   bitmap, bit index {x[4:0], y[4:0]}
//   iStart     in   1      request to snapshot and stream iImage (taken in IDLE only)
//   oBusy      out  1      high from accepted start through the oDone cycle
//   oPixValid  out  1      oPixData/oPixIdx/oLast are valid
//   iPixReady  in   1      downstream accepts the current word
//   oPixData   out  PIX_W  PIX_ON for a set pixel, 0 for a clear one
//   oPixIdx    out  10     stream position of the current word
//   oLast      out  1      current word is position 1023
//   oDone      out  1      one-cycle pulse after the final handshake
//   oPopCount  out  11     set pixels handed over so far / final count
// -----------------------------------------------------------------------------
module image_streamer #(
  parameter int PIX_W  = 8,
  parameter int PIX_ON = 255
) (
  input  logic             iBusClk,
  input  logic             iRst,
  input  logic [1023:0]    iImage,
  input  logic             iStart,
  output logic             oBusy,
  output logic             oPixValid,
  input  logic             iPixReady,
  output logic [PIX_W-1:0] oPixData,
  output logic [9:0]       oPixIdx,
  output logic             oLast,
  output logic             oDone,
  output logic [10:0]      oPopCount
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t        state_reg;
  logic [1023:0] shadow_reg;
  logic [9:0]    pos_reg;
  logic          pix_bit_reg;
  logic          valid_reg;
  logic          last_reg;
  logic          done_reg;
  logic [10:0]   pop_reg;

  // Maps a stream position to the shadow bit it presents.
  function automatic logic [9:0] shadow_addr(input logic [9:0] p);
`ifdef IMG_STREAM_ROW_MAJOR_EN
    return {p[4:0], p[9:5]};
`else
    return p;
`endif
  endfunction

  wire handshake = valid_reg && iPixReady;

  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      state_reg   <= IDLE;
      shadow_reg  <= '0;
      pos_reg     <= '0;
      pix_bit_reg <= 1'b0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      done_reg    <= 1'b0;
      pop_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (iStart) begin
            shadow_reg <= iImage;
            pos_reg    <= '0;
            pop_reg    <= '0;
            state_reg  <= LOAD;
          end
        end
        LOAD: begin
          // Pre-fetch position 0 so the first word is presented from a register.
          pix_bit_reg <= shadow_reg[shadow_addr(10'd0)];
          pos_reg     <= '0;
          valid_reg   <= 1'b1;
          last_reg    <= 1'b0;
          state_reg   <= STREAM;
        end
        STREAM: begin
          // Outputs only move on a handshake, so they hold during stalls.
          if (handshake) begin
            if (pix_bit_reg) begin
              pop_reg <= pop_reg + 11'd1;
            end
            if (pos_reg == 10'd1023) begin
              valid_reg   <= 1'b0;
              last_reg    <= 1'b0;
              pix_bit_reg <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= DONE;
            end else begin
              pos_reg     <= pos_reg + 10'd1;
              pix_bit_reg <= shadow_reg[shadow_addr(pos_reg + 10'd1)];
              last_reg    <= (pos_reg == 10'd1022);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oBusy     = (state_reg != IDLE);
  assign oPixValid = valid_reg;
  assign oPixData  = pix_bit_reg ? PIX_W'(PIX_ON) : '0;
  assign oPixIdx   = pos_reg;
  assign oLast     = last_reg;
  assign oDone     = done_reg;
  assign oPopCount = pop_reg;

endmodule

// File: tb/tb_image_streamer.sv
// -----------------------------------------------------------------------------
// tb_image_streamer
//   Directed bench for image_streamer: one task per scenario, each driving a
//   stream and comparing its observations against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_image_streamer;

  localparam int PIX_ON_T = 255;

  logic          iBusClk = 1'b0;
  logic          iRst = 1'b0;
  logic [1023:0] iImage = '0;
  logic          iStart = 1'b0;
  logic          oBusy;
  logic          oPixValid;
  logic          iPixReady = 1'b0;
  logic [7:0]    oPixData;
  logic [9:0]    oPixIdx;
  logic          oLast;
  logic          oDone;
  logic [10:0]   oPopCount;

  always #5 iBusClk = ~iBusClk;

  image_streamer #(.PIX_W(8), .PIX_ON(PIX_ON_T)) dut (
    .iBusClk   (iBusClk),
    .iRst      (iRst),
    .iImage    (iImage),
    .iStart    (iStart),
    .oBusy     (oBusy),
    .oPixValid (oPixValid),
    .iPixReady (iPixReady),
    .oPixData  (oPixData),
    .oPixIdx   (oPixIdx),
    .oLast     (oLast),
    .oDone     (oDone),
    .oPopCount (oPopCount)
  );

  int checks = 0;
  int errors = 0;

  // Observations gathered by capture().
  int first_valid, hs_cnt, done_cnt, done_cycle, pop_final, model_pop;
  int idx_err, data_err, last_err, stab_err, busy_err, last_seen;
  int nz_cnt, nz_idx, timeout, rst_hit;

  // Expected pixel bit for stream position p.
  function automatic logic exp_bit(input logic [1023:0] img, input int p);
    logic [9:0] q;
    q = p[9:0];
`ifdef IMG_STREAM_ROW_MAJOR_EN
    return img[{q[4:0], q[9:5]}];
`else
    return img[q];
`endif
  endfunction

  // Pulses iStart for one cycle; returns at posedge+1 of the LOAD cycle.
  task automatic do_start(input logic [1023:0] img);
    iImage = img;
    iStart = 1'b1;
    @(posedge iBusClk); #1;
    iStart = 1'b0;
  endtask

  // Runs the stream from the LOAD cycle until oDone (returns in the oDone
  // cycle), until a reset is injected at handshake count rst_at, or timeout.
  task automatic capture(input logic [1023:0] img, input bit rand_ready,
                         input int disturb_at, input int rst_at);
    int   c;
    bit   rdy, hs, pv, phs, disturbed, done_seen;
    logic [9:0] pidx;
    logic [7:0] pdata;
    logic plast;
    c = 1; pv = 0; phs = 0; disturbed = 0; done_seen = 0;
    pidx = '0; pdata = '0; plast = 0;
    first_valid = -1; hs_cnt = 0; done_cnt = 0; done_cycle = -1; pop_final = -1;
    model_pop = 0; idx_err = 0; data_err = 0; last_err = 0; stab_err = 0;
    busy_err = 0; last_seen = 0; nz_cnt = 0; nz_idx = -1; timeout = 0; rst_hit = 0;
    while (c < 3000) begin
      iStart = 1'b0;
      if (oBusy !== 1'b1) busy_err++;
      if (oDone === 1'b1) begin
        done_cnt++; done_cycle = c; pop_final = int'(oPopCount); done_seen = 1;
        break;
      end
      if (oPixValid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (pv && !phs && (oPixIdx !== pidx || oPixData !== pdata || oLast !== plast))
          stab_err++;
        if (oPixIdx !== hs_cnt[9:0]) idx_err++;
        if (oPixData !== (exp_bit(img, hs_cnt) ? 8'(PIX_ON_T) : 8'd0)) data_err++;
        if (oLast !== (hs_cnt == 1023)) last_err++;
      end
      if (rst_at >= 0 && oPixValid === 1'b1 && hs_cnt == rst_at) begin
        iRst = 1'b1; iPixReady = 1'b0; rst_hit = 1;
        @(posedge iBusClk); #1;
        return;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      iPixReady = rdy;
      if (disturb_at >= 0 && !disturbed && hs_cnt == disturb_at) begin
        iImage = ~img; iStart = 1'b1; disturbed = 1;
      end
      hs = (oPixValid === 1'b1) && rdy;
      if (hs) begin
        if (exp_bit(img, hs_cnt)) model_pop++;
        if (oPixData !== 8'd0) begin
          nz_cnt++;
          if (nz_idx < 0) nz_idx = int'(oPixIdx);
        end
        if (oLast === 1'b1) last_seen++;
        hs_cnt++;
      end
      pv = (oPixValid === 1'b1); phs = hs; pidx = oPixIdx; pdata = oPixData; plast = oLast;
      @(posedge iBusClk); #1;
      c++;
    end
    iPixReady = 1'b0;
    iStart = 1'b0;
    if (!done_seen) timeout = 1;
    $display("stream: words=%0d first_valid=%0d done_cycle=%0d popcount=%0d",
             hs_cnt, first_valid, done_cycle, pop_final);
  endtask

  task automatic test_reset();
    iRst = 1'b1; iStart = 1'b1; iImage = '1;
    repeat (3) @(posedge iBusClk);
    #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", oBusy); end
    checks++; if (oPixValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", oPixValid); end
    checks++; if ({oPixData, oPixIdx, oLast, oDone, oPopCount} !== '0) begin
      errors++; $display("FAIL reset_outputs got data=%0d idx=%0d last=%0b done=%0b pop=%0d want all 0",
                         oPixData, oPixIdx, oLast, oDone, oPopCount); end
    iRst = 1'b0; iStart = 1'b0;
    @(posedge iBusClk); #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got %0b want 0", oBusy); end
    $display("reset: busy=%0b valid=%0b pop=%0d", oBusy, oPixValid, oPopCount);
  endtask

  task automatic test_all_ones();
    logic [1023:0] img;
    img = '1;
    do_start(img);
    checks++; if (oBusy !== 1'b1 || oPixValid !== 1'b0) begin errors++;
      $display("FAIL ones_load got busy=%0b valid=%0b want busy=1 valid=0", oBusy, oPixValid); end
    capture(img, 1'b0, -1, -1);
    checks++; if (timeout != 0) begin errors++; $display("FAIL ones_timeout got no oDone want oDone"); end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL ones_latency got %0d want 2", first_valid); end
    checks++; if (hs_cnt != 1024) begin errors++; $display("FAIL ones_words got %0d want 1024", hs_cnt); end
    checks++; if (idx_err + data_err + last_err + busy_err != 0) begin errors++;
      $display("FAIL ones_stream got idx_err=%0d data_err=%0d last_err=%0d busy_err=%0d want 0",
               idx_err, data_err, last_err, busy_err); end
    checks++; if (last_seen != 1) begin errors++; $display("FAIL ones_last got %0d want 1", last_seen); end
    checks++; if (done_cycle != 1026) begin errors++; $display("FAIL ones_done_cycle got %0d want 1026", done_cycle); end
    checks++; if (pop_final != 1024) begin errors++; $display("FAIL ones_pop got %0d want 1024", pop_final); end
    checks++; if (oPixValid !== 1'b0) begin errors++; $display("FAIL ones_valid_at_done got %0b want 0", oPixValid); end
    @(posedge iBusClk); #1;
    checks++; if (oDone !== 1'b0 || oBusy !== 1'b0) begin errors++;
      $display("FAIL ones_after_done got done=%0b busy=%0b want 0 0", oDone, oBusy); end
    checks++; if (oPopCount !== 11'd1024) begin errors++; $display("FAIL ones_pop_held got %0d want 1024", oPopCount); end
  endtask

  task automatic test_all_zeros();
    logic [1023:0] img;
    img = '0;
    do_start(img);
    capture(img, 1'b0, -1, -1);
    checks++; if (timeout != 0 || done_cnt != 1) begin errors++; $display("FAIL zeros_done got %0d want 1", done_cnt); end
    checks++; if (hs_cnt != 1024 || nz_cnt != 0) begin errors++;
      $display("FAIL zeros_words got words=%0d nonzero=%0d want 1024 0", hs_cnt, nz_cnt); end
    checks++; if (pop_final != 0) begin errors++; $display("FAIL zeros_pop got %0d want 0", pop_final); end
    @(posedge iBusClk); #1;
  endtask

  task automatic test_single_bit();
    logic [1023:0] img;
    int exp_idx;
    img = '0;
    img[101] = 1'b1;
`ifdef IMG_STREAM_ROW_MAJOR_EN
    exp_idx = 163;
`else
    exp_idx = 101;
`endif
    do_start(img);
    capture(img, 1'b0, -1, -1);
    checks++; if (timeout != 0 || hs_cnt != 1024) begin errors++; $display("FAIL single_words got %0d want 1024", hs_cnt); end
    checks++; if (nz_cnt != 1) begin errors++; $display("FAIL single_nonzero got %0d want 1", nz_cnt); end
    checks++; if (nz_idx != exp_idx) begin errors++; $display("FAIL single_idx got %0d want %0d", nz_idx, exp_idx); end
    checks++; if (pop_final != 1) begin errors++; $display("FAIL single_pop got %0d want 1", pop_final); end
    @(posedge iBusClk); #1;
  endtask

  task automatic test_random_ready();
    logic [1023:0] img;
    for (int i = 0; i < 32; i++) img[i*32 +: 32] = $urandom;
    do_start(img);
    capture(img, 1'b1, -1, -1);
    checks++; if (timeout != 0 || done_cnt != 1) begin errors++; $display("FAIL rand_done got %0d want 1", done_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stall_stable got %0d want 0", stab_err); end
    checks++; if (idx_err != 0 || hs_cnt != 1024) begin errors++;
      $display("FAIL rand_idx got idx_err=%0d words=%0d want 0 1024", idx_err, hs_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL rand_data got %0d want 0", data_err); end
    checks++; if (pop_final != $countones(img)) begin errors++;
      $display("FAIL rand_pop got %0d want %0d", pop_final, $countones(img)); end
    @(posedge iBusClk); #1;
  endtask

  task automatic test_restart_ignored();
    logic [1023:0] img;
    img = '0;
    for (int i = 0; i < 16; i++) img[i*32 +: 32] = 32'hA5A5_0F0F;  // 16 set bits per word
    do_start(img);
    capture(img, 1'b0, 500, -1);
    checks++; if (timeout != 0 || done_cnt != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
    checks++; if (hs_cnt != 1024 || idx_err != 0) begin errors++;
      $display("FAIL restart_words got words=%0d idx_err=%0d want 1024 0", hs_cnt, idx_err); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL restart_data got %0d want 0", data_err); end
    checks++; if (pop_final != 256) begin errors++; $display("FAIL restart_pop got %0d want 256", pop_final); end
    @(posedge iBusClk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1023:0] img;
    img = '0;
    img[7] = 1'b1;
    do_start(img);
    capture(img, 1'b0, -1, -1);
    // Start presented on the DONE cycle must be dropped.
    iImage = '1; iStart = 1'b1;
    @(posedge iBusClk); #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL b2b_done_start got busy=%0b want 0", oBusy); end
    // Held into the following IDLE cycle, it is taken.
    @(posedge iBusClk); #1;
    iStart = 1'b0;
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL b2b_idle_start got busy=%0b want 1", oBusy); end
    capture('1, 1'b0, -1, -1);
    checks++; if (timeout != 0 || pop_final != 1024) begin errors++; $display("FAIL b2b_pop got %0d want 1024", pop_final); end
    @(posedge iBusClk); #1;
  endtask

  task automatic test_reset_midstream();
    logic [1023:0] img;
    img = '1;
    do_start(img);
    capture(img, 1'b0, -1, 700);
    checks++; if (rst_hit != 1) begin errors++; $display("FAIL midrst_reached got %0d want 1", rst_hit); end
    checks++; if ({oBusy, oPixValid, oPixData, oPixIdx, oLast, oDone, oPopCount} !== '0) begin errors++;
      $display("FAIL midrst_outputs got busy=%0b valid=%0b data=%0d idx=%0d last=%0b done=%0b pop=%0d want all 0",
               oBusy, oPixValid, oPixData, oPixIdx, oLast, oDone, oPopCount); end
    iRst = 1'b0;
    @(posedge iBusClk); #1;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%0b want 0", oBusy); end
    img = '0;
    img[1023] = 1'b1;
    img[0] = 1'b1;
    do_start(img);
    capture(img, 1'b0, -1, -1);
    checks++; if (first_valid != 2 || idx_err != 0 || hs_cnt != 1024) begin errors++;
      $display("FAIL midrst_restart got first_valid=%0d idx_err=%0d words=%0d want 2 0 1024",
               first_valid, idx_err, hs_cnt); end
    checks++; if (pop_final != 2) begin errors++; $display("FAIL midrst_pop got %0d want 2", pop_final); end
    @(posedge iBusClk); #1;
  endtask

  initial begin
    @(posedge iBusClk); #1;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_single_bit();
    test_random_ready();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 Parameter PIX_W, default 8: width of each streamed pixel word.
REQ-002 Parameter PIX_ON, default 255: word value emitted for a set pixel. A clear pixel SHALL emit 0.
REQ-003 iBusClk  input  1  sole clock; all logic on posedge. One clock; reset is synchronous and active-high.
REQ-004 iRst  input  1  synchronous active-high reset.
REQ-005 iImage  input  1024  drawn 32x32 bitmap; bit index = {x[4:0], y[4:0]} (column-major).
REQ-006 iStart  input  1  single-cycle request to snapshot and stream iImage.
REQ-007 oBusy  output  1  high from accepted start until the oDone cycle, inclusive.
REQ-008 oPixValid  output  1  pixel word on oPixData is valid.
REQ-009 iPixReady  input  1  downstream (DNN input layer) accepts the word.
REQ-010 oPixData  output  PIX_W  pixel word, PIX_ON or 0.
REQ-011 oPixIdx  output  10  stream position 0..1023 of the current word.
REQ-012 oLast  output  1  high with oPixValid for position 1023.
REQ-013 oDone  output  1  one-cycle pulse after the final handshake.
REQ-014 oPopCount  output  11  number of set pixels in the snapshot, 0..1024.

Function
REQ-015 FSM states: IDLE, LOAD, STREAM, DONE.
REQ-016 IDLE: iStart=1 SHALL copy iImage into an internal 1024-bit shadow register, clear position and popcount, go to LOAD.
REQ-017 LOAD: one cycle; goes to STREAM; oPixValid asserts on the first STREAM cycle (start-to-first-valid latency 2 cycles).
REQ-018 A handshake occurs on a cycle with oPixValid=1 and iPixReady=1; position increments by 1 per handshake only.
REQ-019 While oPixValid=1 and iPixReady=0, oPixData, oPixIdx and oLast SHALL hold stable.
REQ-020 oPixValid SHALL NOT deassert in STREAM without a handshake.
REQ-021 Sustained iPixReady=1 SHALL yield one word per cycle; 1024 words in 1024 consecutive cycles.
REQ-022 oPopCount increments by 1 on each handshake of a set pixel; saturation unnecessary (max 1024 fits 11 bits).
REQ-023 Handshake at position 1023: STREAM -> DONE; oPixValid deasserts next cycle; no position wrap to 0 is emitted.
REQ-024 DONE: oDone=1 for exactly one cycle, oPopCount final and held until next accepted start; then IDLE.
REQ-025 iStart while oBusy=1 SHALL be ignored; shadow image unaffected by iImage changes during streaming.
REQ-026 iStart on the DONE cycle is ignored; a start on the following IDLE cycle is accepted.
REQ-027 Shadow register indexing SHALL be registered (no combinational path from iPixReady to oPixData).

Reset
REQ-028 iRst=1 on any posedge, including mid-stream: state IDLE, position 0, shadow cleared, oBusy=0, oPixValid=0, oPixData=0, oPixIdx=0, oLast=0, oDone=0, oPopCount=0.
REQ-029 iRst has priority over iStart on the same cycle.

Configuration
REQ-030 Macro IMG_STREAM_ROW_MAJOR_EN.
REQ-031 Defined: stream order row-major -- position p reads shadow bit {p[4:0], p[9:5]} (y outer, x inner); oPixIdx still reports p.
REQ-032 Undefined: stream order column-major -- position p reads shadow bit p directly.

Verification
REQ-033 Reset, iImage all ones, iStart pulse, iPixReady=1 -> valid at cycle 2, 1024 words of 255, oLast at idx 1023, oDone one cycle later, oPopCount=1024.
REQ-034 iImage all zeros -> 1024 words of 0, oPopCount=0, oDone pulses once.
REQ-035 Only bit {x=3,y=5} set (bit 101), column-major build -> nonzero word at oPixIdx=101 only; row-major build -> at oPixIdx=163; oPopCount=1 both.
REQ-036 iPixReady random 50% duty -> data/idx stable during stalls, no dropped or duplicated index, oPopCount equals bit count of snapshot.
REQ-037 iImage changed and iStart re-pulsed at idx 500 -> stream unaffected, second start ignored, oDone once.
REQ-038 iRst at idx 700 -> next cycle all outputs 0, state IDLE; subsequent iStart restarts at idx 0.
